// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants, FSM
// state encoding and the odd-parity helper.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: synchroniser, falling-edge detect, bit timer and the
// three-sample majority vote around the middle of each bit period.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,        // raw asynchronous line
  input  logic i_clear,     // hold the bit timer at 0 (IDLE/BREAK)
  output logic o_rx_s,      // synchronised line
  output logic o_fall,      // rx_s went 1 -> 0 this cycle
  output logic o_bit_tick,  // vote is valid this cycle (cnt == MID+1)
  output logic o_bit_end,   // last cycle of the bit period
  output logic o_bit_val    // majority of the three mid-bit samples
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID_I = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(MID_I - 1);
  localparam logic [CNT_W-1:0] MID_C  = CNT_W'(MID_I);
  localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(MID_I + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_rx_s;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Synchroniser and previous-value flop; reset to the idle level (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b1}};
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_prev <= w_rx_s;
    end
  end

  // Bit timer: free-runs 0..CLKS_PER_BIT-1 unless held clear by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (!i_clear) begin
      if (r_cnt == MID_M1) r_s0 <= w_rx_s;
      if (r_cnt == MID_C)  r_s1 <= w_rx_s;
    end
  end

  assign o_rx_s     = w_rx_s;
  assign o_fall     = r_prev & ~w_rx_s;
  assign o_bit_tick = ~i_clear & (r_cnt == MID_P1);
  assign o_bit_end  = ~i_clear & (r_cnt == LAST);
  assign o_bit_val  = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 1 start, 8 data LSB first, odd parity, stop bit(s).
// Received bytes are held in a valid/ready output register.
// Handshake: a byte transfers on a cycle where rx_valid & rx_ready are both
// high; rx_valid stays high and rx_data/parity_err/frame_err stay stable
// until that transfer happens, and a new delivery overwrites (overrun_err).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs422_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  rx_state_e            r_state;
  rx_state_e            w_next;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_deliver;
  logic                 r_stop_vote;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_pe;
  logic                 r_fe;
  logic                 r_ov;

  logic w_rx_s;
  logic w_fall;
  logic w_bit_tick;
  logic w_bit_end;
  logic w_bit_val;
  logic w_clear;
  logic w_handshake;

  // The timer only runs while a frame is being decoded.
  assign w_clear     = (r_state == ST_IDLE) || (r_state == ST_BREAK);
  assign w_handshake = r_rx_valid & rx_ready;

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rs422_rx),
    .i_clear    (w_clear),
    .o_rx_s     (w_rx_s),
    .o_fall     (w_fall),
    .o_bit_tick (w_bit_tick),
    .o_bit_end  (w_bit_end),
    .o_bit_val  (w_bit_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; STOP leaves at the vote so back-to-back frames fit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall) w_next = ST_START;
      ST_START: begin
        if (w_bit_tick && w_bit_val) w_next = ST_IDLE;  // start glitch
        else if (w_bit_end)          w_next = ST_DATA;
      end
      ST_DATA:   if (w_bit_end && (r_idx == 3'(DATA_BITS - 1))) w_next = ST_PARITY;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_tick) w_next = w_bit_val ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (w_rx_s) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Frame datapath: shift register, bit index, parity flag, delivery strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_deliver   <= 1'b0;
      r_stop_vote <= 1'b1;
    end else begin
      r_deliver <= (r_state == ST_STOP) && w_bit_tick;
      if (r_state == ST_START) begin
        r_idx <= '0;
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_bit_tick) begin
        case (r_state)
          ST_DATA:   r_shift     <= {w_bit_val, r_shift[DATA_BITS-1:1]};
          ST_PARITY: r_perr      <= (w_bit_val != odd_parity(r_shift));
          ST_STOP:   r_stop_vote <= w_bit_val;
          default:   ;
        endcase
      end
    end
  end

  // Output holding register; a delivery takes priority over a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_ov       <= 1'b0;
    end else if (r_deliver) begin
      r_rx_data  <= r_shift;
      r_rx_valid <= 1'b1;
      r_pe       <= r_perr;
      r_fe       <= ~r_stop_vote;
      r_ov       <= r_rx_valid & ~rx_ready;
    end else if (w_handshake) begin
      r_rx_valid <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_ov       <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_pe;
  assign frame_err   = r_fe;
  assign overrun_err = r_ov;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs422_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_deliv  = 0;
  int         idle_cnt = 0;
  logic       watch    = 1'b0;
  logic [9:0] exp_q[$];  // {frame_err, parity_err, data}

  // Clock
  always #5 clk = ~clk;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs422_rx    (rs422_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, landing just after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rs422_rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  // Scoreboard: every accepted byte is compared with the head of exp_q.
  always @(negedge clk) begin
    if (watch && !busy) idle_cnt++;
    if (rst_n && rx_valid && rx_ready) begin
      n_deliv++;
      if (exp_q.size() > 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rx_data", rx_data, e[7:0]);
        check("parity_err", parity_err, e[8]);
        check("frame_err", frame_err, e[9]);
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun_err", overrun_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    // 1: 0x55, parity 1
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    send_frame(8'h55, 1'b1, 1'b1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t1_count", n_deliv, 1);
    check("t1_valid_low", rx_valid, 0);

    // 2: back-to-back 0x01 (p0) and 0xA5 (p1)
    exp_q.push_back({1'b0, 1'b0, 8'h01});
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    fork
      begin
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1);
        rs422_rx = 1'b1;
      end
      begin
        tick(4 * CPB);
        watch = 1'b1;
        tick(16 * CPB);
        watch = 1'b0;
      end
    join
    tick(2 * CPB);
    check("t2_count", n_deliv, 3);
    check("t2_gap_le_bit", idle_cnt <= CPB, 1);
    check("t2_gap_nonzero", idle_cnt > 0, 1);

    // 3a: 0x00 with wrong parity bit 0
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    send_frame(8'h00, 1'b0, 1'b1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t3_parity_count", n_deliv, 4);

    // 3b: 0x3C (p1) with stop bit 0, line then held low
    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(39 * CPB);
    check("t3_break_count", n_deliv, 5);
    check("t3_break_busy", busy, 1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t3_release_count", n_deliv, 5);
    check("t3_release_busy", busy, 0);

    // 4: start glitch of 4 clocks, then 0xFF (p1)
    rs422_rx = 1'b0;
    tick(4);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t4_glitch_busy", busy, 0);
    check("t4_glitch_count", n_deliv, 5);
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    send_frame(8'hFF, 1'b1, 1'b1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t4_ff_count", n_deliv, 6);

    // 5: overrun with consumer stalled, 0x12 (p1) then 0x34 (p0)
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1);
    rs422_rx = 1'b1;
    tick(CPB);
    send_frame(8'h34, 1'b0, 1'b1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t5_valid", rx_valid, 1);
    check("t5_data", rx_data, 8'h34);
    check("t5_overrun", overrun_err, 1);
    check("t5_parity_err", parity_err, 0);
    check("t5_frame_err", frame_err, 0);
    exp_q.push_back({1'b0, 1'b0, 8'h34});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("t5_valid_cleared", rx_valid, 0);
    check("t5_overrun_cleared", overrun_err, 0);
    check("t5_count", n_deliv, 7);
    rx_ready = 1'b1;
    tick(CPB);

    // 6: reset in the middle of the data bits of 0x77
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_overrun", overrun_err, 0);
    rs422_rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2 * CPB);
    check("t6_no_delivery", n_deliv, 7);
    // 0x77 has six ones, so the odd-parity bit is 1
    exp_q.push_back({1'b0, 1'b0, 8'h77});
    send_frame(8'h77, 1'b1, 1'b1);
    rs422_rx = 1'b1;
    tick(2 * CPB);
    check("t6_count", n_deliv, 8);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
